// File: rtl/iterative_divider_if.sv
// Shared types and request/response interface for iterative_divider.
//   iterative_divider_pkg : XLEN default width, div_ops_e opcodes, fu_state_e occupancy.
//   iterative_divider_if  : groups the issue-side request (valid_i, operation_i,
//                           dividend_i, divisor_i, clear_i) and the writeback-side
//                           response (fu_state_o, result_o, valid_o, divide_by_zero_o).
//     master : issue logic / testbench side (drives the *_i signals)
//     slave  : divider side (drives the *_o signals)

package iterative_divider_pkg;
    parameter int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

interface iterative_divider_if #(
    parameter int unsigned WIDTH = iterative_divider_pkg::XLEN
);
    import iterative_divider_pkg::*;

    logic             valid_i;
    div_ops_e         operation_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             clear_i;
    fu_state_e        fu_state_o;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;
    logic             divide_by_zero_o;

    modport master (
        output valid_i, operation_i, dividend_i, divisor_i, clear_i,
        input  fu_state_o, result_o, valid_o, divide_by_zero_o
    );

    modport slave (
        input  valid_i, operation_i, dividend_i, divisor_i, clear_i,
        output fu_state_o, result_o, valid_o, divide_by_zero_o
    );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle restoring radix-2 integer divider with RV32M DIV/DIVU/REM/REMU
// semantics at any WIDTH >= 2.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : iterative_divider_if.slave (request in, FREE/BUSY + registered result out)
// Optional build macro: DIV_EARLY_OUT_EN -- PREP jumps straight to DONE for
// divide-by-zero, overflow and |dividend| < |divisor|.

module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    iterative_divider_if.slave bus
);

    localparam int unsigned      CW       = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, DIVIDE, DONE} state_e;

    state_e           state_q, state_d;
    div_ops_e         op_q;
    logic [WIDTH-1:0] dividend_q, divisor_q;
    logic [WIDTH:0]   dvd_q, b_mag_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             q_neg_q, r_neg_q, div0_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             valid_q, dz_q;

    logic             accept, is_signed, is_rem, div0, ovf, early, ge;
    logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag, trial;
    logic [WIDTH-1:0] q_fix, r_fix, res;

    // Operand preparation works on the latched operands (PREP state).
    always_comb begin
        accept    = (state_q == IDLE) && bus.valid_i && !bus.clear_i;
        is_signed = (op_q == DIV_) || (op_q == REM_);
        is_rem    = (op_q == REM_) || (op_q == REMU_);
        a_ext     = {is_signed & dividend_q[WIDTH-1], dividend_q};
        b_ext     = {is_signed & divisor_q[WIDTH-1], divisor_q};
        a_mag     = a_ext[WIDTH] ? -a_ext : a_ext;
        b_mag     = b_ext[WIDTH] ? -b_ext : b_ext;
        div0      = (divisor_q == '0);
        ovf       = is_signed && (dividend_q == MOST_NEG) && (divisor_q == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = div0 || ovf || (a_mag < b_mag);
`else
        early     = 1'b0;
`endif
    end

    // One restoring step: bring in the next dividend bit (MSB first, picked by
    // the down-counter) and subtract the divisor if it fits.
    always_comb begin
        trial = {rem_q, 1'(dvd_q >> cnt_q)};
        ge    = (trial >= b_mag_q);
    end

    // Sign fix-up and forced special-case results.
    always_comb begin
        q_fix = q_neg_q ? -quot_q : quot_q;
        r_fix = r_neg_q ? -rem_q : rem_q;
        if (div0_q) begin
            q_fix = '1;
            r_fix = dividend_q;
        end else if (ovf_q) begin
            q_fix = dividend_q;
            r_fix = '0;
        end
        res = is_rem ? r_fix : q_fix;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = PREP;
            PREP:    state_d = early ? DONE : DIVIDE;
            DIVIDE:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q       <= DIV_;
            dividend_q <= '0;
            divisor_q  <= '0;
            dvd_q      <= '0;
            b_mag_q    <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                op_q       <= bus.operation_i;
                dividend_q <= bus.dividend_i;
                divisor_q  <= bus.divisor_i;
            end
            if (state_q == PREP) begin
                dvd_q   <= a_mag;
                b_mag_q <= b_mag;
                q_neg_q <= is_signed & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
                r_neg_q <= is_signed & dividend_q[WIDTH-1];
                div0_q  <= div0;
                ovf_q   <= ovf;
                cnt_q   <= CW'(WIDTH - 1);
                quot_q  <= '0;
                // Early-out for |a| < |b| leaves the dividend as the remainder.
                rem_q   <= early ? WIDTH'(a_mag) : '0;
            end
            if (state_q == DIVIDE) begin
                rem_q  <= ge ? WIDTH'(trial - b_mag_q) : WIDTH'(trial);
                quot_q <= {quot_q[WIDTH-2:0], ge};
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            if ((state_q == DONE) && !bus.clear_i) begin
                result_q <= res;
                dz_q     <= div0_q;
                valid_q  <= 1'b1;
            end
        end
    end

    assign bus.fu_state_o       = (state_q == IDLE) ? FREE : BUSY;
    assign bus.result_o         = result_q;
    assign bus.valid_o          = valid_q;
    assign bus.divide_by_zero_o = dz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases plus randomized
// operations on a WIDTH=32 and a WIDTH=8 instance, compared against a plain
// arithmetic reference model (result, divide-by-zero flag and latency).
// Honours DIV_EARLY_OUT_EN for the expected latency.

module tb_iterative_divider;
    import iterative_divider_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iterative_divider_if #(.WIDTH(32)) bus32();
    iterative_divider_if #(.WIDTH(8))  bus8();

    iterative_divider #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus32.slave));
    iterative_divider #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus8.slave));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics via 64-bit arithmetic.
    task automatic ref_op(input int op, input int w, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic dz, output int lat);
        longint mask, ua, ub, xa, xb, q, r, minv;
        bit sgn, early;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        minv = -(longint'(1) << (w - 1));
        sgn  = (op == 0) || (op == 2);
        xa   = ua;
        xb   = ub;
        if (sgn && ua >= (longint'(1) << (w - 1))) xa = ua - (longint'(1) << w);
        if (sgn && ub >= (longint'(1) << (w - 1))) xb = ub - (longint'(1) << w);
        dz = 1'b0;
        if (ub == 0) begin
            q = mask; r = ua; dz = 1'b1; early = 1'b1;
        end else if (sgn && xa == minv && xb == -1) begin
            q = ua; r = 0; early = 1'b1;
        end else begin
            q = xa / xb;
            r = xa % xb;
            early = ((xa < 0) ? -xa : xa) < ((xb < 0) ? -xb : xb);
        end
        res = 32'(((op >= 2) ? r : q) & mask);
`ifdef DIV_EARLY_OUT_EN
        lat = early ? 2 : w + 2;
`else
        lat = w + 2;
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int inst, input logic v, input int op, input logic [31:0] a, input logic [31:0] b);
        if (inst == 0) begin
            bus32.valid_i     = v;
            bus32.operation_i = div_ops_e'(op[1:0]);
            bus32.dividend_i  = a;
            bus32.divisor_i   = b;
        end else begin
            bus8.valid_i     = v;
            bus8.operation_i = div_ops_e'(op[1:0]);
            bus8.dividend_i  = a[7:0];
            bus8.divisor_i   = b[7:0];
        end
    endtask

    function automatic logic is_free(input int inst);
        return (inst == 0) ? (bus32.fu_state_o == FREE) : (bus8.fu_state_o == FREE);
    endfunction

    function automatic logic get_valid(input int inst);
        return (inst == 0) ? bus32.valid_o : bus8.valid_o;
    endfunction

    function automatic logic [31:0] get_res(input int inst);
        return (inst == 0) ? bus32.result_o : {24'd0, bus8.result_o};
    endfunction

    function automatic logic get_dz(input int inst);
        return (inst == 0) ? bus32.divide_by_zero_o : bus8.divide_by_zero_o;
    endfunction

    // Waits (bounded) for FREE, presents the request and returns #1 after the accept edge.
    task automatic start_op(input string tag, input int inst, input int op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!is_free(inst) && n < 100) begin
            tick(1);
            n++;
        end
        check({tag, "_free_before"}, 64'(is_free(inst)), 64'd1);
        set_req(inst, 1'b1, op, a, b);
        tick(1);
        set_req(inst, 1'b0, op, ~a, ~b);   // operands must already be latched
        check({tag, "_busy"}, 64'(is_free(inst)), 64'd0);
    endtask

    // Waits (bounded) for valid_o; elapsed = cycles already spent since accept.
    task automatic finish_op(input string tag, input int inst, input int op, input logic [31:0] a,
                             input logic [31:0] b, input int elapsed);
        logic [31:0] exp_res;
        logic exp_dz;
        int exp_lat, w, cyc, seen;
        w = (inst == 0) ? 32 : 8;
        ref_op(op, w, a, b, exp_res, exp_dz, exp_lat);
        cyc  = elapsed;
        seen = 0;
        while (seen == 0 && cyc < w + 12) begin
            tick(1);
            cyc++;
            if (get_valid(inst)) seen = cyc;
        end
        check({tag, "_latency"}, 64'(seen), 64'(exp_lat));
        check({tag, "_result"}, 64'(get_res(inst)), 64'(exp_res));
        check({tag, "_dz"}, 64'(get_dz(inst)), 64'(exp_dz));
        tick(1);
        check({tag, "_pulse"}, 64'(get_valid(inst)), 64'd0);
    endtask

    task automatic run_op(input string tag, input int inst, input int op, input logic [31:0] a, input logic [31:0] b);
        start_op(tag, inst, op, a, b);
        finish_op(tag, inst, op, a, b, 0);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom % 7)
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'(64'(1) << (w - 1));
            4:       v = 32'($urandom % 16);
            5:       v = 32'($urandom) >> ($urandom % 32);
            default: v = 32'($urandom);
        endcase
        return (w == 32) ? v : (v & 32'hFF);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [31:0] held;
        set_req(0, 1'b0, 0, '0, '0);
        set_req(1, 1'b0, 0, '0, '0);
        bus32.clear_i = 1'b0;
        bus8.clear_i  = 1'b0;

        #12;
        check("rst_free",   64'(is_free(0)),   64'd1);
        check("rst_valid",  64'(get_valid(0)), 64'd0);
        check("rst_result", 64'(get_res(0)),   64'd0);
        check("rst_dz",     64'(get_dz(0)),    64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Directed cases
        run_op("divu_100_7",  0, 1, 32'd100, 32'd7);
        run_op("remu_100_7",  0, 3, 32'd100, 32'd7);
        run_op("div_m7_2",    0, 0, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",    0, 2, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2",    0, 0, 32'd7, 32'hFFFF_FFFE);
        run_op("div_5_0",     0, 0, 32'd5, 32'd0);
        run_op("remu_5_0",    0, 3, 32'd5, 32'd0);
        run_op("div_ovf",     0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",     0, 2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_3_10",   0, 1, 32'd3, 32'd10);
        run_op("remu_3_10",   0, 3, 32'd3, 32'd10);
        run_op("divu_max_1",  0, 1, 32'hFFFF_FFFF, 32'd1);
        run_op("w8_divu_200", 1, 1, 32'd200, 32'd3);
        run_op("w8_div_ovf",  1, 0, 32'h80, 32'hFF);

        // Request while BUSY is ignored and not queued
        start_op("busy", 0, 1, 32'd1000, 32'd10);
        tick(4);
        set_req(0, 1'b1, 0, 32'd77, 32'd0);
        tick(1);
        set_req(0, 1'b0, 0, 32'd0, 32'd0);
        finish_op("busy", 0, 1, 32'd1000, 32'd10, 5);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (get_valid(0)) seen++;
            tick(1);
        end
        check("busy_noqueue", 64'(seen), 64'd0);

        // clear_i mid-operation
        held = get_res(0);
        start_op("clr", 0, 1, 32'd12345, 32'd17);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            if (get_valid(0)) seen++;
        end
        bus32.clear_i = 1'b1;
        tick(1);
        bus32.clear_i = 1'b0;
        check("clr_free",   64'(is_free(0)),   64'd1);
        check("clr_valid",  64'(seen + int'(get_valid(0))), 64'd0);
        check("clr_result", 64'(get_res(0)),   64'(held));
        run_op("after_clr", 0, 2, 32'hFFFF_FF00, 32'd7);

        // Asynchronous reset mid-operation
        start_op("arst", 0, 1, 32'd999, 32'd5);
        tick(19);
        rst_n = 1'b0;
        #1;
        check("arst_free",   64'(is_free(0)),   64'd1);
        check("arst_valid",  64'(get_valid(0)), 64'd0);
        check("arst_result", 64'(get_res(0)),   64'd0);
        check("arst_dz",     64'(get_dz(0)),    64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        run_op("after_rst", 0, 1, 32'd999, 32'd5);

        // Randomized operations on both widths
        for (int i = 0; i < 160; i++) begin
            int inst, op, w;
            logic [31:0] a, b;
            inst = (($urandom % 5) == 0) ? 1 : 0;
            w    = (inst == 0) ? 32 : 8;
            op   = int'($urandom % 4);
            a    = pick(w);
            b    = pick(w);
            run_op($sformatf("rnd%0d_w%0d_op%0d", i, w, op), inst, op, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Parametrised multi-cycle integer divider implementing the RV32M DIV/DIVU/REM/REMU semantics at any operand width. Sits in the execute stage beside the ALU and multiplier, receiving operands and a `div_ops_e` opcode from issue logic. It reports occupancy through `fu_state_e` and returns a single-cycle-valid result to writeback. It supersedes the fixed-32-bit divider with a width parameter, flush support, explicit divide-by-zero flagging and an optional early-out path.

## Interface
- `WIDTH`, default `XLEN` (32): operand/result width, must be ≥ 2.
- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `valid_i`  in  1  request strobe; sampled only while FREE.
- `operation_i`  in  2 (`div_ops_e`)  DIV_, DIVU_, REM_, REMU_.
- `dividend_i`  in  WIDTH  rs1 operand.
- `divisor_i`  in  WIDTH  rs2 operand.
- `clear_i`  in  1  synchronous flush; kills the in-flight operation.
- `fu_state_o`  out  1 (`fu_state_e`)  FREE/BUSY.
- `result_o`  out  WIDTH  quotient or remainder, registered.
- `valid_o`  out  1  one-cycle result strobe.
- `divide_by_zero_o`  out  1  divisor was zero; qualified by `valid_o`.

## Operation
- FSM states:
  - IDLE → PREP on `valid_i`. Operands and opcode are latched on the accept edge.
  - PREP → DIVIDE, or → DONE on the early-out path.
  - DIVIDE → DONE after WIDTH iterations.
  - DONE → IDLE unconditionally.
- `fu_state_o`: FREE only in IDLE, BUSY otherwise. `valid_i` while BUSY is ignored; no queuing.
- PREP:
  - Compute magnitudes in WIDTH+1 bits so the most-negative value is representable. Signed ops take abs(); unsigned ops zero-extend.
  - Record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a). Both signs are forced 0 for DIVU_/REMU_.
  - Detect divide-by-zero (divisor == 0).
  - Detect overflow: DIV_/REM_ with dividend = 1 followed by WIDTH−1 zeros and divisor = all ones.
- DIVIDE: restoring radix-2, one quotient bit per cycle, MSB first. Iteration counter is $clog2(WIDTH)+1 bits and counts WIDTH−1 down to 0.
- DONE: apply the sign fixes, select quotient (DIV_/DIVU_) or remainder (REM_/REMU_), register into `result_o`, pulse `valid_o`.
- Forced results, which override the datapath regardless of the path taken:
  - Divide by zero: quotient = all ones, remainder = dividend, `divide_by_zero_o` = 1.
  - Overflow: quotient = dividend (most-negative), remainder = 0, `divide_by_zero_o` = 0.
- `clear_i` (any state): next state IDLE, no `valid_o`, `result_o` unchanged. `clear_i` takes priority over `valid_i` in the same cycle.
- `result_o` and `divide_by_zero_o` hold their last values until the next DONE.

## Timing
- Reset values: `fu_state_o` = FREE, `result_o` = 0, `valid_o` = 0, `divide_by_zero_o` = 0, FSM = IDLE, counter = 0.
- Reset asserted mid-operation aborts immediately with no result.
- Accept edge = cycle 0. PREP = cycle 1. DIVIDE = cycles 2..WIDTH+1. DONE (`valid_o` = 1) = cycle WIDTH+2, so latency is 34 for WIDTH = 32.
- Early-out (macro enabled): PREP at cycle 1, DONE at cycle 2, latency 2.
- Back-to-back throughput: a new request is accepted on the cycle after DONE, so one operation per WIDTH+3 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `DIV_EARLY_OUT_EN` defined: PREP branches directly to DONE in three cases:
  - divide-by-zero;
  - overflow;
  - |dividend| < |divisor|, giving quotient 0 and remainder = dividend.
- `DIV_EARLY_OUT_EN` undefined: every operation takes WIDTH+2 cycles. Special cases still produce the forced results listed under Operation.

## Test plan
- DIVU_ 100 / 7 → `result_o` = 14 with `valid_o` at cycle 34; REMU_ with the same operands → 2.
- DIV_ 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM_ with the same operands → 0xFFFFFFFF; DIV_ 7 / 0xFFFFFFFE → 0xFFFFFFFD.
- DIV_ 5 / 0 → 0xFFFFFFFF with `divide_by_zero_o` = 1; REMU_ 5 / 0 → 5. Valid at cycle 34 without the macro, cycle 2 with it.
- DIV_ 0x80000000 / 0xFFFFFFFF → 0x80000000; REM_ with the same operands → 0; `divide_by_zero_o` = 0 in both.
- Request issued while BUSY is ignored. `clear_i` at cycle 10 → no `valid_o`, FREE at cycle 11, and a new request is accepted at cycle 11. `rst_n_i` low at cycle 20 → all outputs at reset values immediately.
- With `DIV_EARLY_OUT_EN`: DIVU_ 3 / 10 → 0 at cycle 2, and REMU_ with the same operands → 3 at cycle 2. WIDTH = 8, DIVU_ 200 / 3 → 66 at cycle 10.
